// File: rtl/fifo_unpack_pack.sv
// Drains a registered-read FIFO and packs RATIO narrow words (first word in
// the LSBs) into one wide word presented on a valid/ready output.
module fifo_unpack_pack #(
  parameter int BITWIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iClr,
  input  logic                          iEmpty,
  output logic                          oEnR,
  input  logic [BITWIDTH-1:0]           iData,
  output logic [BITWIDTH*RATIO-1:0]     oData,
  output logic                          oValid,
  input  logic                          iReady,
  output logic [$clog2(RATIO+1)-1:0]    oCnt
);
  localparam int CW = $clog2(RATIO+1);
  localparam logic [CW-1:0] LAST     = CW'(RATIO-1);
  localparam logic [CW-1:0] FULL     = CW'(RATIO);
  localparam logic [CW:0]   FILL_MAX = (CW+1)'(RATIO);

  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               pend_q, pend_d;
  logic [RATIO-1:0][BITWIDTH-1:0]     pbuf_q, pbuf_d;
  logic [BITWIDTH*RATIO-1:0]          odata_q, odata_d;
  logic                               ovalid_q, ovalid_d;
  logic [CW:0]                        fill;
  logic                               enr, slot_free;

  // Words held plus the one in flight; never request more than the buffer holds.
  assign fill      = {1'b0, cnt_q} + (CW+1)'(pend_q);
  assign enr       = ~iEmpty & ~iClr & ~iRst & (fill < FILL_MAX);
  assign slot_free = ~ovalid_q | iReady;

  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = enr;
    pbuf_d   = pbuf_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q & ~iReady;
    if (cnt_q == FULL) begin
      // Stalled complete word waits for the output register to drain.
      if (slot_free) begin
        odata_d  = pbuf_q;
        ovalid_d = 1'b1;
        cnt_d    = '0;
      end
    end else if (pend_q) begin
      for (int i = 0; i < RATIO; i++)
        if (cnt_q == CW'(i)) pbuf_d[i] = iData;
      if (cnt_q == LAST) begin
        if (slot_free) begin
          odata_d  = {iData, pbuf_q[RATIO-2:0]};
          ovalid_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = FULL;
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst || iClr) begin
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Buffer contents are don't-care after flush; cnt alone tracks validity.
  always_ff @(posedge iClk) pbuf_q <= pbuf_d;

  assign oEnR   = enr;
  assign oData  = odata_q;
  assign oValid = ovalid_q;
  assign oCnt   = cnt_q;
endmodule

// File: tb/tb_fifo_unpack_pack.sv
// Bench for fifo_unpack_pack: a queue-based FIFO model feeds the DUT, a
// word-stream model predicts packed beats, a negedge monitor checks them.
module tb_fifo_unpack_pack;
  localparam int W = 8;
  localparam int R = 4;
  localparam int CW = $clog2(R+1);

  logic            iClk = 0, iRst = 1, iClr = 0, iReady = 0;
  logic            iEmpty, oEnR, oValid;
  logic [W-1:0]    iData;
  logic [W*R-1:0]  oData;
  logic [CW-1:0]   oCnt;

  fifo_unpack_pack #(.BITWIDTH(W), .RATIO(R)) dut (
    .iClk(iClk), .iRst(iRst), .iClr(iClr), .iEmpty(iEmpty), .oEnR(oEnR),
    .iData(iData), .oData(oData), .oValid(oValid), .iReady(iReady), .oCnt(oCnt)
  );

  always #5 iClk = ~iClk;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_rd = 0, n_beats = 0;
  int t_enr = -1, t_val = -1;
  bit arm = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // FIFO with one-cycle registered read, plus the reference word-stream model.
  logic [W-1:0]     fq[$];
  logic [W-1:0]     words[$];
  logic [W*R-1:0]   exp_q[$];
  int               fcnt = 0;
  logic             push_v = 0;
  logic [W-1:0]     push_d = '0;
  logic [W-1:0]     rdata = '0;
  assign iEmpty = (fcnt == 0);
  assign iData  = rdata;

  always @(posedge iClk) begin
    cyc <= cyc + 1;
    if (iRst || iClr) begin
      fq.delete(); words.delete(); exp_q.delete();
      fcnt <= 0;
    end else begin
      if (oEnR && fq.size() > 0) rdata <= fq.pop_front();
      if (push_v) begin
        fq.push_back(push_d);
        words.push_back(push_d);
        if (words.size() == R) begin
          logic [W*R-1:0] b;
          for (int i = 0; i < R; i++) b[i*W +: W] = words[i];
          exp_q.push_back(b);
          words.delete();
        end
      end
      fcnt <= fq.size();
    end
  end

  // Monitor: handshakes are decided by values stable at the negedge.
  logic [W*R-1:0] held;
  bit hold_v = 0;
  always @(negedge iClk) begin
    if (oEnR) n_rd++;
    if (arm) begin
      if (oEnR && t_enr < 0) t_enr = cyc;
      if (oValid && t_val < 0) t_val = cyc;
    end
    if (!iRst && oValid && iReady) begin
      n_beats++;
      if (exp_q.size() == 0) chk("unexpected_beat", oData, 64'hx);
      else chk("beat_data", oData, exp_q.pop_front());
    end
    if (!iRst && oValid && !iReady) begin
      if (hold_v) chk("stall_stable", oData, held);
      held = oData; hold_v = 1;
    end else hold_v = 0;
  end

  task automatic step(); @(posedge iClk); #1; endtask
  task automatic push(input logic [W-1:0] d);
    push_v = 1; push_d = d; step(); push_v = 0;
  endtask
  task automatic idle(input int n); repeat (n) step(); endtask
  task automatic wait_beats(input int target, input int bound);
    for (int i = 0; i < bound && n_beats < target; i++) step();
    chk("beat_count", n_beats, target);
  endtask

  initial begin
    int b0, r0;
    // Reset state
    step(); step();
    @(negedge iClk); chk("rst_enr", oEnR, 0);
    step(); iRst = 0;
    @(negedge iClk);
    chk("rst_valid", oValid, 0); chk("rst_data", oData, 0); chk("rst_cnt", oCnt, 0);

    // Basic pack + latency
    step(); iReady = 1; arm = 1; b0 = n_beats;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_beats(b0 + 1, 20);
    arm = 0;
    chk("pack_latency", t_val - t_enr, R + 1);
    idle(2); @(negedge iClk); chk("basic_cnt", oCnt, 0);

    // Streaming
    step(); b0 = n_beats; r0 = n_rd;
    for (int i = 0; i < 16; i++) push(8'(i));
    wait_beats(b0 + 4, 40);
    chk("stream_reads", n_rd - r0, 16);

    // Backpressure
    step(); iReady = 0; b0 = n_beats;
    for (int i = 0; i < 12; i++) push(8'h20 + 8'(i));
    idle(20);
    @(negedge iClk);
    chk("bp_cnt", oCnt, R); chk("bp_enr", oEnR, 0); chk("bp_fifo", fcnt, 4);
    chk("bp_valid", oValid, 1); chk("bp_data", oData, 32'h23222120);
    step(); iReady = 1;
    wait_beats(b0 + 3, 40);

    // Underflow stall
    step(); b0 = n_beats;
    push(8'h51); push(8'h52); push(8'h53);
    idle(20);
    @(negedge iClk); chk("uf_valid", oValid, 0); chk("uf_cnt", oCnt, 3);
    step(); push(8'hAA);
    wait_beats(b0 + 1, 20);

    // Flush mid-pack: iClr in the cycle where the second read's data arrives
    step(); b0 = n_beats;
    push(8'h61); push(8'h62); step();
    iClr = 1; step(); iClr = 0;
    @(negedge iClk); chk("fl_cnt", oCnt, 0); chk("fl_valid", oValid, 0);
    step();
    push(8'h71); push(8'h72); push(8'h73); push(8'h74);
    idle(8);
    chk("fl_beats", n_beats, b0 + 1);

    // Reset during a held output
    step(); iReady = 0;
    for (int i = 0; i < 9; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 30 && !oValid; i++) step();
    idle(10);
    iRst = 1;
    @(negedge iClk); chk("rh_enr", oEnR, 0);
    step(); iRst = 0;
    @(negedge iClk);
    chk("rh_valid", oValid, 0); chk("rh_data", oData, 0); chk("rh_cnt", oCnt, 0);

    // Randomized traffic with occasional flushes
    step();
    for (int i = 0; i < 3000; i++) begin
      iReady = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        iClr = 1; push_v = 0; step(); iClr = 0;
      end else begin
        push_v = ($urandom_range(0, 9) < 6);
        push_d = 8'($urandom);
        step();
      end
    end
    push_v = 0; iReady = 1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || fcnt != 0); i++) step();
    idle(4);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_fifo", fcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_unpack_pack.md
# fifo_unpack_pack

Downstream drain stage for the synchronous FIFO. It pops `BITWIDTH`-bit words through the FIFO read port and absorbs the FIFO's one-cycle registered read latency. It packs `RATIO` consecutive words into one wide word, first word in the LSBs, and presents the result on a valid/ready output. It connects directly to the FIFO's read-enable, empty and read-data ports, and feeds any wider-datapath consumer.

## Interface
- `BITWIDTH`, default 8: FIFO word width.
- `RATIO`, default 4: words per packed output; must be ≥ 2.
- `iClk`  in  1: clock; all state updates on the rising edge.
- `iRst`  in  1: synchronous, active-high reset.
- `iClr`  in  1: synchronous flush. Drive it in the same cycle as the FIFO's clear.
- `iEmpty`  in  1: FIFO empty flag.
- `oEnR`  out  1: FIFO read enable; combinational.
- `iData`  in  `BITWIDTH`: FIFO read data; valid the cycle after a read is accepted.
- `oData`  out  `BITWIDTH*RATIO`: packed word, registered.
- `oValid`  out  1: `oData` holds a packed word; registered.
- `iReady`  in  1: consumer accepts `oData` when `oValid & iReady`.
- `oCnt`  out  `$clog2(RATIO+1)`: words currently held in the pack buffer; registered.

## Operation
- **State**
  - `cnt` (0..`RATIO`): words held in the pack buffer.
  - `pend` (1 bit): a read was issued last cycle and its data arrives this cycle.
  - `buf`: `RATIO`×`BITWIDTH` pack buffer.
  - Output register: `oData` plus `oValid`.
- **Read issue:** `oEnR = ~iEmpty & ~iClr & ~iRst & (cnt + pend < RATIO)`. No read is issued that the buffer cannot hold. `pend` <= `oEnR`.
- **Capture:** when `pend` = 1, `iData` is written to slot `cnt`, i.e. bits `[cnt*BITWIDTH +: BITWIDTH]`, and `cnt` increments.
- **Output slot free:** defined as `~oValid | iReady`.
- **Load on completion:** if a capture fills slot `RATIO-1` and the output slot is free, in that same edge:
  - `oData` <= {`iData`, `buf[RATIO-2:0]`}
  - `oValid` <= 1
  - `cnt` <= 0
- **Stall on completion:** if a capture fills slot `RATIO-1` and the output slot is not free, `cnt` becomes `RATIO`. The buffer then loads into `oData` on the first edge where the output slot is free, and `cnt` <= 0. No reads are issued while `cnt` = `RATIO`.
- **Handshake:** `oValid` falls after an `oValid & iReady` edge, unless a new load happens on that same edge; then `oValid` stays 1 with the new `oData`. `oData` is stable while `oValid & ~iReady`.
- **Flush:** `iClr` (when `iRst` = 0) forces, at that edge:
  - `cnt`=0, `pend`=0, `oValid`=0, `oData`=0
  - buffer contents are don't-care
  - any in-flight read datum is discarded
- **Reset:** `iRst` has the same effect as flush and takes priority over everything. Reset mid-pack drops the partial word.
- **Arithmetic:** `cnt + pend` is computed one bit wider than `cnt`; no wrap.

## Timing
- **Reset values:** `oEnR`=0 while `iRst`=1; `oData`=0, `oValid`=0, `oCnt`=0.
- **Read latency:** `oEnR` high in cycle t means `iData` is valid in cycle t+1 and captured at the end of t+1.
- **Pack latency:** with a non-empty FIFO and `iReady`=1, the first `oEnR` in cycle t gives `oValid`=1 in cycle t+`RATIO`+1.
- **Steady-state throughput:** `RATIO` words per `RATIO`+1 cycles. One bubble per pack occurs because `cnt + pend` reaches `RATIO` on the last read.
- **FIFO goes empty mid-pack:** `oEnR` drops and the partial word is held indefinitely. A flush drops it.
- **Output full and buffer full:** FIFO reads stop, so the FIFO provides backpressure to its producer.
- **Simultaneous `iClr` and `oValid & iReady`:** the flush wins; the word counts as consumed and `oValid`=0 next cycle.
- **Simultaneous capture and handshake:** both take effect on the same edge.

## Test plan
All scenarios use `BITWIDTH`=8, `RATIO`=4.
- **Basic pack:** push 0x11, 0x22, 0x33, 0x44 into the FIFO with `iReady`=1 → exactly one beat with `oData`=0x44332211. `oValid` rises 5 cycles after the first `oEnR`, then `oCnt`=0.
- **Streaming:** push 0x00..0x0F continuously with `iReady`=1 → four beats: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. One `oEnR`-low bubble per beat; no lost or duplicated word.
- **Backpressure:** 12 words pushed, `iReady`=0 → first beat held stable, `oCnt` reaches 4, `oEnR` stays 0 with 4 words left in the FIFO. When `iReady` goes to 1, the remaining beats arrive in order with no gaps in the data.
- **Underflow stall:** push 3 words, then wait 20 cycles → `oValid` stays 0 and `oCnt`=3. Push a 4th word, 0xAA → `oData`=0xAA{w2}{w1}{w0}.
- **Flush mid-pack:** push 2 words, assert `iClr` together with the FIFO clear in the cycle after a read → `oCnt`=0 and `oValid`=0. The next 4 words pack cleanly with no stale bytes.
- **Reset during a held output:** `oValid`=1 with `iReady`=0, assert `iRst` for 1 cycle → next cycle `oValid`=0, `oData`=0, `oCnt`=0, and `oEnR`=0 during the reset cycle.
